// File: rtl/control_pipeline_pkg.sv
// rtl/control_pipeline_pkg.sv - bus widths, bit indices, BUBBLE constants and forward codes for the control pipeline.
package control_pipeline_pkg;

  localparam int EXEC_BUS_WIDTH = 7;
  localparam int MEM_BUS_WIDTH  = 3;
  localparam int WB_BUS_WIDTH   = 2;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 16;

  localparam int EX_ALU_OP_LSB  = 0;
  localparam int EX_ALU_OP_MSB  = 3;
  localparam int EX_ALU_SRC     = 4;
  localparam int EX_REG_DST     = 5;
  localparam int EX_SHAMT_FLAG  = 6;

  localparam int MEM_WRITE      = 0;
  localparam int MEM_READ       = 1;
  localparam int MEM_BRANCH     = 2;

  localparam int WB_MEM_TO_REG  = 0;
  localparam int WB_REG_WRITE   = 1;

  localparam logic [EXEC_BUS_WIDTH-1:0] EXEC_BUBBLE = 7'b0001111;
  localparam logic [MEM_BUS_WIDTH-1:0]  MEM_BUBBLE  = '0;
  localparam logic [WB_BUS_WIDTH-1:0]   WB_BUBBLE   = '0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM_WB  = 2'b01,
    FWD_EX_MEM  = 2'b10
  } fwd_sel_e;

  // How the stage registers move on the coming edge.
  typedef enum logic [1:0] {
    ADV_NORMAL,
    ADV_HAZARD,
    ADV_FLUSH,
    ADV_HOLD
  } adv_e;

  function automatic logic [REG_ADDR_WIDTH-1:0] dest_select(
    input logic                      reg_dst,
    input logic                      reg_write,
    input logic [REG_ADDR_WIDTH-1:0] rt,
    input logic [REG_ADDR_WIDTH-1:0] rd
  );
    if (!reg_write) return '0;
    return reg_dst ? rd : rt;
  endfunction

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(
    input logic [REG_ADDR_WIDTH-1:0] dest,
    input logic [REG_ADDR_WIDTH-1:0] src
  );
    return (dest != '0) && (dest == src);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// rtl/control_pipeline_if.sv - decoder-side inputs and per-stage control outputs of the control pipeline.
interface control_pipeline_if;
  import control_pipeline_pkg::*;

  logic                      enable;
  logic                      branch_taken;
  logic [EXEC_BUS_WIDTH-1:0] id_execute_bus;
  logic [MEM_BUS_WIDTH-1:0]  id_memory_bus;
  logic [WB_BUS_WIDTH-1:0]   id_wb_bus;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;

  logic [EXEC_BUS_WIDTH-1:0] ex_execute_bus;
  logic [MEM_BUS_WIDTH-1:0]  ex_memory_bus;
  logic [WB_BUS_WIDTH-1:0]   ex_wb_bus;
  logic [MEM_BUS_WIDTH-1:0]  mem_memory_bus;
  logic [WB_BUS_WIDTH-1:0]   mem_wb_bus;
  logic [WB_BUS_WIDTH-1:0]   wb_wb_bus;
  logic [REG_ADDR_WIDTH-1:0] ex_dest;
  logic [REG_ADDR_WIDTH-1:0] mem_dest;
  logic [REG_ADDR_WIDTH-1:0] wb_dest;
  logic [1:0]                forward_a;
  logic [1:0]                forward_b;
  logic                      stall;
  logic                      if_id_flush;
  logic [CNT_WIDTH-1:0]      bubble_count;

  modport master (
    output enable, branch_taken, id_execute_bus, id_memory_bus, id_wb_bus, id_rs, id_rt, id_rd,
    input  ex_execute_bus, ex_memory_bus, ex_wb_bus, mem_memory_bus, mem_wb_bus, wb_wb_bus,
           ex_dest, mem_dest, wb_dest, forward_a, forward_b, stall, if_id_flush, bubble_count
  );

  modport slave (
    input  enable, branch_taken, id_execute_bus, id_memory_bus, id_wb_bus, id_rs, id_rt, id_rd,
    output ex_execute_bus, ex_memory_bus, ex_wb_bus, mem_memory_bus, mem_wb_bus, wb_wb_bus,
           ex_dest, mem_dest, wb_dest, forward_a, forward_b, stall, if_id_flush, bubble_count
  );

endinterface

// File: rtl/control_pipeline_hazard_detect.sv
// rtl/control_pipeline_hazard_detect.sv - register dependency compares producing hazard and ALU forward selects.
// FORWARDING_EN: forward from EX/MEM and MEM/WB and stall only on load-use; otherwise stall on any RAW in EX/MEM.
module control_pipeline_hazard_detect
  import control_pipeline_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
  input  logic                      ex_mem_read_i,
  input  logic                      ex_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dest_i,
  input  logic                      mem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dest_i,
`ifdef FORWARDING_EN
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt_i,
  input  logic                      wb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_dest_i,
`endif
  output logic                      hazard_o,
  output logic [1:0]                forward_a_o,
  output logic [1:0]                forward_b_o
);

  logic     ex_match;
  logic     load_use;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  assign ex_match = reg_match(ex_dest_i, id_rs_i) || reg_match(ex_dest_i, id_rt_i);
  assign load_use = ex_mem_read_i && ex_reg_write_i && ex_match;

`ifdef FORWARDING_EN
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    // The younger producer (in MEM) takes priority over the one in WB.
    if (mem_reg_write_i && reg_match(mem_dest_i, ex_rs_i)) fwd_a = FWD_EX_MEM;
    else if (wb_reg_write_i && reg_match(wb_dest_i, ex_rs_i)) fwd_a = FWD_MEM_WB;
    if (mem_reg_write_i && reg_match(mem_dest_i, ex_rt_i)) fwd_b = FWD_EX_MEM;
    else if (wb_reg_write_i && reg_match(wb_dest_i, ex_rt_i)) fwd_b = FWD_MEM_WB;
  end

  assign hazard_o = load_use;
`else
  logic raw_ex;
  logic raw_mem;

  assign fwd_a   = FWD_REGFILE;
  assign fwd_b   = FWD_REGFILE;
  assign raw_ex  = ex_reg_write_i && ex_match;
  // WB writes the regfile in the first half-cycle, so only EX and MEM producers stall.
  assign raw_mem = mem_reg_write_i &&
                   (reg_match(mem_dest_i, id_rs_i) || reg_match(mem_dest_i, id_rt_i));

  assign hazard_o = load_use || raw_ex || raw_mem;
`endif

  assign forward_a_o = fwd_a;
  assign forward_b_o = fwd_b;

endmodule

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use and branch bubble insertion.
// FORWARDING_EN: ID/EX also carries rs/rt for forward selection.
module control_pipeline
  import control_pipeline_pkg::*;
(
  input logic               clk,
  input logic               reset,
  control_pipeline_if.slave bus
);

  logic [EXEC_BUS_WIDTH-1:0] ex_exec_q, ex_exec_d;
  logic [MEM_BUS_WIDTH-1:0]  ex_mem_q, ex_mem_d;
  logic [WB_BUS_WIDTH-1:0]   ex_wb_q, ex_wb_d;
  logic [REG_ADDR_WIDTH-1:0] ex_dest_q, ex_dest_d;
  logic [MEM_BUS_WIDTH-1:0]  mem_mem_q, mem_mem_d;
  logic [WB_BUS_WIDTH-1:0]   mem_wb_q, mem_wb_d;
  logic [REG_ADDR_WIDTH-1:0] mem_dest_q, mem_dest_d;
  logic [WB_BUS_WIDTH-1:0]   wb_wb_q, wb_wb_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;
`ifdef FORWARDING_EN
  logic [REG_ADDR_WIDTH-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rt_q, ex_rt_d;
`endif

  logic [REG_ADDR_WIDTH-1:0] id_dest;
  logic                      hazard;
  logic [1:0]                fwd_a;
  logic [1:0]                fwd_b;
  adv_e                      adv;
  logic [1:0]                bubbles;

  assign id_dest = dest_select(bus.id_execute_bus[EX_REG_DST], bus.id_wb_bus[WB_REG_WRITE],
                               bus.id_rt, bus.id_rd);

  control_pipeline_hazard_detect u_hazard (
    .id_rs_i         (bus.id_rs),
    .id_rt_i         (bus.id_rt),
    .ex_mem_read_i   (ex_mem_q[MEM_READ]),
    .ex_reg_write_i  (ex_wb_q[WB_REG_WRITE]),
    .ex_dest_i       (ex_dest_q),
    .mem_reg_write_i (mem_wb_q[WB_REG_WRITE]),
    .mem_dest_i      (mem_dest_q),
`ifdef FORWARDING_EN
    .ex_rs_i         (ex_rs_q),
    .ex_rt_i         (ex_rt_q),
    .wb_reg_write_i  (wb_wb_q[WB_REG_WRITE]),
    .wb_dest_i       (wb_dest_q),
`endif
    .hazard_o        (hazard),
    .forward_a_o     (fwd_a),
    .forward_b_o     (fwd_b)
  );

  // A taken branch squashes both wrong-path slots, which already covers any pending hazard.
  always_comb begin
    adv     = ADV_NORMAL;
    bubbles = 2'd0;
    if (!bus.enable) begin
      adv = ADV_HOLD;
    end else if (bus.branch_taken) begin
      adv     = ADV_FLUSH;
      bubbles = 2'd2;
    end else if (hazard) begin
      adv     = ADV_HAZARD;
      bubbles = 2'd1;
    end
  end

  always_comb begin
    ex_exec_d    = ex_exec_q;
    ex_mem_d     = ex_mem_q;
    ex_wb_d      = ex_wb_q;
    ex_dest_d    = ex_dest_q;
    mem_mem_d    = mem_mem_q;
    mem_wb_d     = mem_wb_q;
    mem_dest_d   = mem_dest_q;
    wb_wb_d      = wb_wb_q;
    wb_dest_d    = wb_dest_q;
    bubble_cnt_d = sat_add(bubble_cnt_q, bubbles);
`ifdef FORWARDING_EN
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
`endif
    if (adv != ADV_HOLD) begin
      wb_wb_d   = mem_wb_q;
      wb_dest_d = mem_dest_q;
      if (adv == ADV_FLUSH) begin
        mem_mem_d  = MEM_BUBBLE;
        mem_wb_d   = WB_BUBBLE;
        mem_dest_d = '0;
      end else begin
        mem_mem_d  = ex_mem_q;
        mem_wb_d   = ex_wb_q;
        mem_dest_d = ex_dest_q;
      end
      if (adv == ADV_NORMAL) begin
        ex_exec_d = bus.id_execute_bus;
        ex_mem_d  = bus.id_memory_bus;
        ex_wb_d   = bus.id_wb_bus;
        ex_dest_d = id_dest;
`ifdef FORWARDING_EN
        ex_rs_d   = bus.id_rs;
        ex_rt_d   = bus.id_rt;
`endif
      end else begin
        ex_exec_d = EXEC_BUBBLE;
        ex_mem_d  = MEM_BUBBLE;
        ex_wb_d   = WB_BUBBLE;
        ex_dest_d = '0;
`ifdef FORWARDING_EN
        ex_rs_d   = '0;
        ex_rt_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_exec_q    <= EXEC_BUBBLE;
      ex_mem_q     <= MEM_BUBBLE;
      ex_wb_q      <= WB_BUBBLE;
      ex_dest_q    <= '0;
      mem_mem_q    <= MEM_BUBBLE;
      mem_wb_q     <= WB_BUBBLE;
      mem_dest_q   <= '0;
      wb_wb_q      <= WB_BUBBLE;
      wb_dest_q    <= '0;
      bubble_cnt_q <= '0;
`ifdef FORWARDING_EN
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
`endif
    end else begin
      ex_exec_q    <= ex_exec_d;
      ex_mem_q     <= ex_mem_d;
      ex_wb_q      <= ex_wb_d;
      ex_dest_q    <= ex_dest_d;
      mem_mem_q    <= mem_mem_d;
      mem_wb_q     <= mem_wb_d;
      mem_dest_q   <= mem_dest_d;
      wb_wb_q      <= wb_wb_d;
      wb_dest_q    <= wb_dest_d;
      bubble_cnt_q <= bubble_cnt_d;
`ifdef FORWARDING_EN
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
`endif
    end
  end

  assign bus.ex_execute_bus = ex_exec_q;
  assign bus.ex_memory_bus  = ex_mem_q;
  assign bus.ex_wb_bus      = ex_wb_q;
  assign bus.mem_memory_bus = mem_mem_q;
  assign bus.mem_wb_bus     = mem_wb_q;
  assign bus.wb_wb_bus      = wb_wb_q;
  assign bus.ex_dest        = ex_dest_q;
  assign bus.mem_dest       = mem_dest_q;
  assign bus.wb_dest        = wb_dest_q;
  assign bus.forward_a      = fwd_a;
  assign bus.forward_b      = fwd_b;
  assign bus.stall          = (adv == ADV_HAZARD);
  assign bus.if_id_flush    = (adv == ADV_FLUSH);
  assign bus.bubble_count   = bubble_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - directed bench for control_pipeline; expectations follow FORWARDING_EN when defined.
module tb_control_pipeline;

  logic clk = 1'b0;
  logic reset;

  control_pipeline_if bif ();

  control_pipeline dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] X_BUB = 7'b0001111;
  localparam logic [6:0] X_LW  = 7'b0010010;
  localparam logic [6:0] X_ADD = 7'b0100010;
  localparam logic [6:0] X_SUB = 7'b0100110;
  localparam logic [6:0] X_BEQ = 7'b0000110;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bif.id_execute_bus = ex;
    bif.id_memory_bus  = mem;
    bif.id_wb_bus      = wb;
    bif.id_rs          = rs;
    bif.id_rt          = rt;
    bif.id_rd          = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bif.enable = 1'b1;
    bif.branch_taken = 1'b0;
    set_id(X_BUB, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
    #2;
    check("rst_ex_exec", bif.ex_execute_bus, X_BUB);
    check("rst_ex_mem", bif.ex_memory_bus, 3'b000);
    check("rst_ex_wb", bif.ex_wb_bus, 2'b00);
    check("rst_mem_mem", bif.mem_memory_bus, 3'b000);
    check("rst_mem_wb", bif.mem_wb_bus, 2'b00);
    check("rst_wb_wb", bif.wb_wb_bus, 2'b00);
    check("rst_dests", {bif.ex_dest, bif.mem_dest, bif.wb_dest}, 15'd0);
    check("rst_fwd", {bif.forward_a, bif.forward_b}, 4'b0000);
    check("rst_stall", bif.stall, 1'b0);
    check("rst_flush", bif.if_id_flush, 1'b0);
    check("rst_count", bif.bubble_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw $2, 0($0) followed by add $3,$2,$4
    set_id(X_LW, 3'b010, 2'b11, 5'd0, 5'd2, 5'd0);
    tick();
    check("lw_ex_exec", bif.ex_execute_bus, X_LW);
    check("lw_ex_dest", bif.ex_dest, 5'd2);
    set_id(X_ADD, 3'b000, 2'b10, 5'd2, 5'd4, 5'd3);
    #1;
    check("lu_stall", bif.stall, 1'b1);
    tick();
    check("lu_ex_bubble", bif.ex_execute_bus, X_BUB);
    check("lu_mem_mem", bif.mem_memory_bus, 3'b010);
    check("lu_mem_wb", bif.mem_wb_bus, 2'b11);
    check("lu_mem_dest", bif.mem_dest, 5'd2);
    check("lu_count1", bif.bubble_count, 16'd1);
`ifdef FORWARDING_EN
    check("lu_stall_done", bif.stall, 1'b0);
    tick();
    check("lu_ex_add", bif.ex_execute_bus, X_ADD);
    check("lu_ex_dest", bif.ex_dest, 5'd3);
    check("lu_fwd_a", bif.forward_a, 2'b01);
    check("lu_fwd_b", bif.forward_b, 2'b00);
    check("lu_count_final", bif.bubble_count, 16'd1);
`else
    check("lu_stall2", bif.stall, 1'b1);
    tick();
    check("lu_ex_bubble2", bif.ex_execute_bus, X_BUB);
    check("lu_wb_wb", bif.wb_wb_bus, 2'b11);
    check("lu_wb_dest", bif.wb_dest, 5'd2);
    check("lu_count2", bif.bubble_count, 16'd2);
    check("lu_stall_done", bif.stall, 1'b0);
    tick();
    check("lu_ex_add", bif.ex_execute_bus, X_ADD);
    check("lu_ex_dest", bif.ex_dest, 5'd3);
    check("lu_count_final", bif.bubble_count, 16'd2);
`endif

    // asynchronous reset with live state, checked before any clock edge
    set_id(X_BUB, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    #1;
    check("arst_ex_exec", bif.ex_execute_bus, X_BUB);
    check("arst_ex_wb", bif.ex_wb_bus, 2'b00);
    check("arst_ex_dest", bif.ex_dest, 5'd0);
    check("arst_count", bif.bubble_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw $9, beq (resolved taken in MEM), add $7, then re-fetch add $8
    set_id(X_LW, 3'b010, 2'b11, 5'd0, 5'd9, 5'd0);
    tick();
    set_id(X_BEQ, 3'b100, 2'b01, 5'd1, 5'd1, 5'd0);
    tick();
    set_id(X_ADD, 3'b000, 2'b10, 5'd0, 5'd0, 5'd7);
    tick();
    check("br_mem_mem", bif.mem_memory_bus, 3'b100);
    check("br_wb_wb_pre", bif.wb_wb_bus, 2'b11);
    check("br_ex_dest_pre", bif.ex_dest, 5'd7);
    set_id(X_ADD, 3'b000, 2'b10, 5'd0, 5'd0, 5'd8);
    bif.branch_taken = 1'b1;
    #1;
    check("br_flush", bif.if_id_flush, 1'b1);
    check("br_stall", bif.stall, 1'b0);
    tick();
    check("br_ex_exec", bif.ex_execute_bus, X_BUB);
    check("br_ex_wb", bif.ex_wb_bus, 2'b00);
    check("br_ex_dest", bif.ex_dest, 5'd0);
    check("br_mem_mem_post", bif.mem_memory_bus, 3'b000);
    check("br_mem_dest", bif.mem_dest, 5'd0);
    check("br_wb_wb", bif.wb_wb_bus, 2'b01);
    check("br_wb_dest", bif.wb_dest, 5'd0);
    check("br_count", bif.bubble_count, 16'd2);
    bif.branch_taken = 1'b0;
    tick();
    check("br_refetch_exec", bif.ex_execute_bus, X_ADD);
    check("br_refetch_dest", bif.ex_dest, 5'd8);
    check("br_refetch_count", bif.bubble_count, 16'd2);

    // taken branch in the same cycle as a load-use hazard
    do_reset();
    set_id(X_LW, 3'b010, 2'b11, 5'd0, 5'd2, 5'd0);
    tick();
    set_id(X_ADD, 3'b000, 2'b10, 5'd2, 5'd4, 5'd3);
    bif.branch_taken = 1'b1;
    #1;
    check("bh_stall", bif.stall, 1'b0);
    check("bh_flush", bif.if_id_flush, 1'b1);
    tick();
    check("bh_ex_exec", bif.ex_execute_bus, X_BUB);
    check("bh_mem_mem", bif.mem_memory_bus, 3'b000);
    check("bh_count", bif.bubble_count, 16'd2);
    bif.branch_taken = 1'b0;
    #1;
    check("bh_no_extra_stall", bif.stall, 1'b0);
    tick();
    check("bh_ex_add", bif.ex_execute_bus, X_ADD);
    check("bh_ex_dest", bif.ex_dest, 5'd3);
    check("bh_count_final", bif.bubble_count, 16'd2);

    // enable low: everything frozen and both strobes suppressed
    bif.enable = 1'b0;
    bif.branch_taken = 1'b1;
    set_id(X_LW, 3'b010, 2'b11, 5'd3, 5'd3, 5'd0);
    #1;
    check("en_stall", bif.stall, 1'b0);
    check("en_flush", bif.if_id_flush, 1'b0);
    repeat (5) tick();
    check("en_ex_exec", bif.ex_execute_bus, X_ADD);
    check("en_ex_dest", bif.ex_dest, 5'd3);
    check("en_mem_wb", bif.mem_wb_bus, 2'b00);
    check("en_count", bif.bubble_count, 16'd2);
    bif.enable = 1'b1;
    bif.branch_taken = 1'b0;

    // add $5 then sub $6,$5,$5
    do_reset();
    set_id(X_ADD, 3'b000, 2'b10, 5'd0, 5'd0, 5'd5);
    tick();
    set_id(X_SUB, 3'b000, 2'b10, 5'd5, 5'd5, 5'd6);
    #1;
`ifdef FORWARDING_EN
    check("raw_stall", bif.stall, 1'b0);
    tick();
    check("raw_ex_exec", bif.ex_execute_bus, X_SUB);
    check("raw_ex_dest", bif.ex_dest, 5'd6);
    check("raw_fwd_a", bif.forward_a, 2'b10);
    check("raw_fwd_b", bif.forward_b, 2'b10);
    check("raw_count", bif.bubble_count, 16'd0);
`else
    check("raw_stall1", bif.stall, 1'b1);
    check("raw_fwd_a", bif.forward_a, 2'b00);
    tick();
    check("raw_stall2", bif.stall, 1'b1);
    check("raw_mem_dest", bif.mem_dest, 5'd5);
    check("raw_count1", bif.bubble_count, 16'd1);
    tick();
    check("raw_stall3", bif.stall, 1'b0);
    check("raw_wb_dest", bif.wb_dest, 5'd5);
    check("raw_count2", bif.bubble_count, 16'd2);
    tick();
    check("raw_ex_exec", bif.ex_execute_bus, X_SUB);
    check("raw_ex_dest", bif.ex_dest, 5'd6);
    check("raw_fwd_b", bif.forward_b, 2'b00);
`endif

    // saturation: two bubbles per edge while a branch is held taken
    do_reset();
    set_id(X_BUB, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
    bif.branch_taken = 1'b1;
    repeat (32767) tick();
    check("sat_below", bif.bubble_count, 16'hFFFE);
    tick();
    check("sat_clamp", bif.bubble_count, 16'hFFFF);
    tick();
    check("sat_hold", bif.bubble_count, 16'hFFFF);
    bif.branch_taken = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
